// File: rtl/axi4lite_reg_slice.sv
// axi4lite_reg_slice
//
// Full-throughput AXI4-Lite register slice. Every forward channel (AW, W, AR) passes through a
// two-entry skid buffer so that no valid, ready or payload path is combinational between the
// s_axi_* side and the m_axi_* side, while a back-to-back stream still moves one beat per cycle.
// Beats are never reordered, merged, dropped or altered.
//
// Configuration macro: AXI4LITE_REG_SLICE_RESP_SLICE_EN
//   defined   - B and R also get skid buffers (all five channels isolated, +1 cycle response).
//   undefined - B and R are wired straight through (zero response latency).
//
// Ports
//   aclk, areset       clock; synchronous active-high reset
//   s_axi_aw*/w*/ar*   upstream request channels (valid/payload in, ready out)
//   s_axi_b*/r*        upstream response channels (valid/payload out, ready in)
//   m_axi_aw*/w*/ar*   downstream request channels toward the adapter
//   m_axi_b*/r*        downstream response channels from the adapter
//
// Per-slice states: EMPTY (out_valid=0), ONE (out_valid=1, skid_valid=0),
// FULL (out_valid=1, skid_valid=1, in_ready=0).

module axi4lite_reg_slice #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  // upstream write address
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  // upstream write data
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  // upstream write response
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // upstream read address
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  // upstream read data
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  // downstream write address
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // downstream write data
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // downstream write response
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  // downstream read address
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  // downstream read data
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int unsigned AxWidth = ADDR_WIDTH + 3;
  localparam int unsigned WWidth  = DATA_WIDTH + DATA_WIDTH / 8;

  // Each slice: output register, skid register, registered ready. The ready register resets to 1
  // (skid empty) but is masked by areset so that every ready reads 0 while reset is held and 1 in
  // the very first cycle after release. Payload only loads into the output register when it is
  // empty or being popped, so a stalled output never changes.

  // ---------------------------------------------------------------- AW slice
  logic [AxWidth-1:0] aw_in, aw_out_q, aw_out_d, aw_skid_q, aw_skid_d;
  logic aw_ov_q, aw_ov_d, aw_sv_q, aw_sv_d, aw_rdy_q, aw_rdy, aw_push, aw_pop;

  assign aw_in   = {s_axi_awaddr, s_axi_awprot};
  assign aw_rdy  = aw_rdy_q & ~areset;
  assign aw_push = s_axi_awvalid & aw_rdy;
  assign aw_pop  = aw_ov_q & m_axi_awready;

  always_comb begin
    aw_out_d  = aw_out_q;
    aw_skid_d = aw_skid_q;
    aw_ov_d   = aw_ov_q;
    aw_sv_d   = aw_sv_q;
    if (!aw_ov_q || aw_pop) begin
      if (aw_sv_q) begin
        aw_out_d = aw_skid_q;  // FULL + pop: skid moves up, output stays valid
        aw_sv_d  = 1'b0;
      end else begin
        aw_ov_d = aw_push;
        if (aw_push) aw_out_d = aw_in;
      end
    end else if (aw_push) begin
      aw_sv_d   = 1'b1;
      aw_skid_d = aw_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_out_q  <= '0;
      aw_skid_q <= '0;
      aw_ov_q   <= 1'b0;
      aw_sv_q   <= 1'b0;
      aw_rdy_q  <= 1'b1;
    end else begin
      aw_out_q  <= aw_out_d;
      aw_skid_q <= aw_skid_d;
      aw_ov_q   <= aw_ov_d;
      aw_sv_q   <= aw_sv_d;
      aw_rdy_q  <= ~aw_sv_d;
    end
  end

  assign {m_axi_awaddr, m_axi_awprot} = aw_out_q;
  assign m_axi_awvalid = aw_ov_q;
  assign s_axi_awready = aw_rdy;

  // ---------------------------------------------------------------- W slice
  logic [WWidth-1:0] w_in, w_out_q, w_out_d, w_skid_q, w_skid_d;
  logic w_ov_q, w_ov_d, w_sv_q, w_sv_d, w_rdy_q, w_rdy, w_push, w_pop;

  assign w_in   = {s_axi_wdata, s_axi_wstrb};
  assign w_rdy  = w_rdy_q & ~areset;
  assign w_push = s_axi_wvalid & w_rdy;
  assign w_pop  = w_ov_q & m_axi_wready;

  always_comb begin
    w_out_d  = w_out_q;
    w_skid_d = w_skid_q;
    w_ov_d   = w_ov_q;
    w_sv_d   = w_sv_q;
    if (!w_ov_q || w_pop) begin
      if (w_sv_q) begin
        w_out_d = w_skid_q;
        w_sv_d  = 1'b0;
      end else begin
        w_ov_d = w_push;
        if (w_push) w_out_d = w_in;
      end
    end else if (w_push) begin
      w_sv_d   = 1'b1;
      w_skid_d = w_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_out_q  <= '0;
      w_skid_q <= '0;
      w_ov_q   <= 1'b0;
      w_sv_q   <= 1'b0;
      w_rdy_q  <= 1'b1;
    end else begin
      w_out_q  <= w_out_d;
      w_skid_q <= w_skid_d;
      w_ov_q   <= w_ov_d;
      w_sv_q   <= w_sv_d;
      w_rdy_q  <= ~w_sv_d;
    end
  end

  assign {m_axi_wdata, m_axi_wstrb} = w_out_q;
  assign m_axi_wvalid = w_ov_q;
  assign s_axi_wready = w_rdy;

  // ---------------------------------------------------------------- AR slice
  logic [AxWidth-1:0] ar_in, ar_out_q, ar_out_d, ar_skid_q, ar_skid_d;
  logic ar_ov_q, ar_ov_d, ar_sv_q, ar_sv_d, ar_rdy_q, ar_rdy, ar_push, ar_pop;

  assign ar_in   = {s_axi_araddr, s_axi_arprot};
  assign ar_rdy  = ar_rdy_q & ~areset;
  assign ar_push = s_axi_arvalid & ar_rdy;
  assign ar_pop  = ar_ov_q & m_axi_arready;

  always_comb begin
    ar_out_d  = ar_out_q;
    ar_skid_d = ar_skid_q;
    ar_ov_d   = ar_ov_q;
    ar_sv_d   = ar_sv_q;
    if (!ar_ov_q || ar_pop) begin
      if (ar_sv_q) begin
        ar_out_d = ar_skid_q;
        ar_sv_d  = 1'b0;
      end else begin
        ar_ov_d = ar_push;
        if (ar_push) ar_out_d = ar_in;
      end
    end else if (ar_push) begin
      ar_sv_d   = 1'b1;
      ar_skid_d = ar_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_out_q  <= '0;
      ar_skid_q <= '0;
      ar_ov_q   <= 1'b0;
      ar_sv_q   <= 1'b0;
      ar_rdy_q  <= 1'b1;
    end else begin
      ar_out_q  <= ar_out_d;
      ar_skid_q <= ar_skid_d;
      ar_ov_q   <= ar_ov_d;
      ar_sv_q   <= ar_sv_d;
      ar_rdy_q  <= ~ar_sv_d;
    end
  end

  assign {m_axi_araddr, m_axi_arprot} = ar_out_q;
  assign m_axi_arvalid = ar_ov_q;
  assign s_axi_arready = ar_rdy;

`ifdef AXI4LITE_REG_SLICE_RESP_SLICE_EN
  // ---------------------------------------------------------------- B slice (m -> s)
  logic [1:0] b_in, b_out_q, b_out_d, b_skid_q, b_skid_d;
  logic b_ov_q, b_ov_d, b_sv_q, b_sv_d, b_rdy_q, b_rdy, b_push, b_pop;

  assign b_in   = m_axi_bresp;
  assign b_rdy  = b_rdy_q & ~areset;
  assign b_push = m_axi_bvalid & b_rdy;
  assign b_pop  = b_ov_q & s_axi_bready;

  always_comb begin
    b_out_d  = b_out_q;
    b_skid_d = b_skid_q;
    b_ov_d   = b_ov_q;
    b_sv_d   = b_sv_q;
    if (!b_ov_q || b_pop) begin
      if (b_sv_q) begin
        b_out_d = b_skid_q;
        b_sv_d  = 1'b0;
      end else begin
        b_ov_d = b_push;
        if (b_push) b_out_d = b_in;
      end
    end else if (b_push) begin
      b_sv_d   = 1'b1;
      b_skid_d = b_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      b_out_q  <= '0;
      b_skid_q <= '0;
      b_ov_q   <= 1'b0;
      b_sv_q   <= 1'b0;
      b_rdy_q  <= 1'b1;
    end else begin
      b_out_q  <= b_out_d;
      b_skid_q <= b_skid_d;
      b_ov_q   <= b_ov_d;
      b_sv_q   <= b_sv_d;
      b_rdy_q  <= ~b_sv_d;
    end
  end

  assign s_axi_bresp  = b_out_q;
  assign s_axi_bvalid = b_ov_q;
  assign m_axi_bready = b_rdy;

  // ---------------------------------------------------------------- R slice (m -> s)
  logic [DATA_WIDTH+1:0] r_in, r_out_q, r_out_d, r_skid_q, r_skid_d;
  logic r_ov_q, r_ov_d, r_sv_q, r_sv_d, r_rdy_q, r_rdy, r_push, r_pop;

  assign r_in   = {m_axi_rdata, m_axi_rresp};
  assign r_rdy  = r_rdy_q & ~areset;
  assign r_push = m_axi_rvalid & r_rdy;
  assign r_pop  = r_ov_q & s_axi_rready;

  always_comb begin
    r_out_d  = r_out_q;
    r_skid_d = r_skid_q;
    r_ov_d   = r_ov_q;
    r_sv_d   = r_sv_q;
    if (!r_ov_q || r_pop) begin
      if (r_sv_q) begin
        r_out_d = r_skid_q;
        r_sv_d  = 1'b0;
      end else begin
        r_ov_d = r_push;
        if (r_push) r_out_d = r_in;
      end
    end else if (r_push) begin
      r_sv_d   = 1'b1;
      r_skid_d = r_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out_q  <= '0;
      r_skid_q <= '0;
      r_ov_q   <= 1'b0;
      r_sv_q   <= 1'b0;
      r_rdy_q  <= 1'b1;
    end else begin
      r_out_q  <= r_out_d;
      r_skid_q <= r_skid_d;
      r_ov_q   <= r_ov_d;
      r_sv_q   <= r_sv_d;
      r_rdy_q  <= ~r_sv_d;
    end
  end

  assign {s_axi_rdata, s_axi_rresp} = r_out_q;
  assign s_axi_rvalid = r_ov_q;
  assign m_axi_rready = r_rdy;
`else
  // Responses pass straight through; the adapter's B/R outputs are assumed registered.
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;
`endif

endmodule

// File: tb/tb_axi4lite_reg_slice.sv
// Directed bench for axi4lite_reg_slice plus a randomly stalled AR/R scoreboard run.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.

module tb_axi4lite_reg_slice;

`ifdef AXI4LITE_REG_SLICE_RESP_SLICE_EN
  localparam bit RespSlice = 1'b1;
`else
  localparam bit RespSlice = 1'b0;
`endif
  localparam int NumBeats = 10000;

  logic        aclk, areset;
  logic [31:0] s_axi_awaddr;  logic [2:0] s_axi_awprot;  logic s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;   logic [3:0] s_axi_wstrb;   logic s_axi_wvalid,  s_axi_wready;
  logic [1:0]  s_axi_bresp;   logic s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;  logic [2:0] s_axi_arprot;  logic s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;   logic [1:0] s_axi_rresp;   logic s_axi_rvalid,  s_axi_rready;
  logic [31:0] m_axi_awaddr;  logic [2:0] m_axi_awprot;  logic m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;   logic [3:0] m_axi_wstrb;   logic m_axi_wvalid,  m_axi_wready;
  logic [1:0]  m_axi_bresp;   logic m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;  logic [2:0] m_axi_arprot;  logic m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;   logic [1:0] m_axi_rresp;   logic m_axi_rvalid,  m_axi_rready;

  int n_tests = 0;
  int n_fail  = 0;

  axi4lite_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // B response: visible same cycle when passed through, one cycle later when sliced.
  task automatic resp_b(input logic [1:0] resp);
    step();
    m_axi_bvalid = 1'b1; m_axi_bresp = resp; s_axi_bready = 1'b1;
    settle();
    check("b_first_cycle_valid", s_axi_bvalid, !RespSlice);
    check("b_mready", m_axi_bready, 1'b1);
    step();
    m_axi_bvalid = 1'b0;
    settle();
    check("b_second_cycle_valid", s_axi_bvalid, RespSlice);
    check("b_resp", s_axi_bresp, resp);
    step();
    settle();
    check("b_drained", s_axi_bvalid, 1'b0);
  endtask

  task automatic resp_r(input logic [31:0] data, input logic [1:0] resp);
    step();
    m_axi_rvalid = 1'b1; m_axi_rdata = data; m_axi_rresp = resp; s_axi_rready = 1'b1;
    settle();
    check("r_first_cycle_valid", s_axi_rvalid, !RespSlice);
    step();
    m_axi_rvalid = 1'b0;
    settle();
    check("r_second_cycle_valid", s_axi_rvalid, RespSlice);
    check("r_data", s_axi_rdata, data);
    check("r_resp", s_axi_rresp, resp);
    step();
    settle();
    check("r_drained", s_axi_rvalid, 1'b0);
  endtask

  // ---------------------------------------------------------------- scoreboard monitors
  bit          sb_on = 1'b0;
  logic [34:0] ar_q[$];
  logic [33:0] r_q[$];
  int          ar_done = 0;
  int          r_done  = 0;
  logic        ar_stall = 1'b0, r_stall = 1'b0;
  logic [34:0] ar_prev = '0;
  logic [33:0] r_prev  = '0;

  always @(negedge aclk) begin
    if (sb_on) begin
      if (s_axi_arvalid && s_axi_arready) ar_q.push_back({s_axi_araddr, s_axi_arprot});
      if (ar_stall) begin
        check("ar_hold_valid", m_axi_arvalid, 1'b1);
        check("ar_hold_payload", {m_axi_araddr, m_axi_arprot}, ar_prev);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        check("ar_sb_nonempty", ar_q.size() != 0, 1'b1);
        if (ar_q.size() != 0) check("ar_sb_payload", {m_axi_araddr, m_axi_arprot}, ar_q.pop_front());
        ar_done <= ar_done + 1;
      end
      ar_stall <= m_axi_arvalid && !m_axi_arready;
      ar_prev  <= {m_axi_araddr, m_axi_arprot};

      if (m_axi_rvalid && m_axi_rready) r_q.push_back({m_axi_rdata, m_axi_rresp});
      if (r_stall) begin
        check("r_hold_valid", s_axi_rvalid, 1'b1);
        check("r_hold_payload", {s_axi_rdata, s_axi_rresp}, r_prev);
      end
      if (s_axi_rvalid && s_axi_rready) begin
        check("r_sb_nonempty", r_q.size() != 0, 1'b1);
        if (r_q.size() != 0) check("r_sb_payload", {s_axi_rdata, s_axi_rresp}, r_q.pop_front());
        r_done <= r_done + 1;
      end
      r_stall <= s_axi_rvalid && !s_axi_rready;
      r_prev  <= {s_axi_rdata, s_axi_rresp};
    end
  end

  // Backpressure table (AW): source valid/addr, sink ready, expected upstream ready,
  // expected downstream valid/addr for each cycle.
  logic        bp_sv  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  logic [31:0] bp_src [8] = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h108, 0, 0};
  logic        bp_mr  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic        bp_srdy[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
  logic        bp_mv  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  logic [31:0] bp_madr[8] = '{0, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h108, 0};

  initial begin
    logic ar_hs, r_hs;
    int   ar_sent, r_sent;

    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b1;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bresp = '0; m_axi_bvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;

    // ---- reset held for three edges with all upstream valids high
    repeat (3) begin
      step();
      settle();
      check("rst_awready", s_axi_awready, 1'b0);
      check("rst_wready", s_axi_wready, 1'b0);
      check("rst_arready", s_axi_arready, 1'b0);
      check("rst_m_awvalid", m_axi_awvalid, 1'b0);
      check("rst_m_wvalid", m_axi_wvalid, 1'b0);
      check("rst_m_arvalid", m_axi_arvalid, 1'b0);
      check("rst_m_awaddr", m_axi_awaddr, 32'h0);
      check("rst_bvalid", s_axi_bvalid, 1'b0);
      check("rst_rvalid", s_axi_rvalid, 1'b0);
      check("rst_bready", m_axi_bready, 1'b0);
      check("rst_rready", m_axi_rready, 1'b0);
    end
    areset = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    settle();
    check("rel_awready", s_axi_awready, 1'b1);
    check("rel_wready", s_axi_wready, 1'b1);
    check("rel_arready", s_axi_arready, 1'b1);
    check("rel_bready", m_axi_bready, RespSlice);
    step();
    settle();
    check("rel_no_awvalid", m_axi_awvalid, 1'b0);
    check("rel_no_wvalid", m_axi_wvalid, 1'b0);
    check("rel_no_arvalid", m_axi_arvalid, 1'b0);

    // ---- single write
    step();
    s_axi_awaddr = 32'h10; s_axi_awprot = 3'b010; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    settle();
    check("wr_pre_awvalid", m_axi_awvalid, 1'b0);
    check("wr_awready", s_axi_awready, 1'b1);
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    settle();
    check("wr_awvalid", m_axi_awvalid, 1'b1);
    check("wr_awaddr", m_axi_awaddr, 32'h10);
    check("wr_awprot", m_axi_awprot, 3'b010);
    check("wr_wvalid", m_axi_wvalid, 1'b1);
    check("wr_wdata", m_axi_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", m_axi_wstrb, 4'hF);
    step();
    settle();
    check("wr_post_awvalid", m_axi_awvalid, 1'b0);
    check("wr_post_wvalid", m_axi_wvalid, 1'b0);
    resp_b(2'b00);
    resp_b(2'b10);

    // ---- 16 back-to-back reads
    for (int i = 0; i <= 16; i++) begin
      step();
      s_axi_arvalid = (i < 16);
      s_axi_araddr  = 32'(i * 4);
      settle();
      if (i < 16) check("ar_stream_ready", s_axi_arready, 1'b1);
      if (i > 0) begin
        check("ar_stream_valid", m_axi_arvalid, 1'b1);
        check("ar_stream_addr", m_axi_araddr, 32'((i - 1) * 4));
      end
    end
    step();
    settle();
    check("ar_stream_end", m_axi_arvalid, 1'b0);

    // ---- AW backpressure into the skid register
    for (int c = 0; c < 8; c++) begin
      step();
      s_axi_awvalid = bp_sv[c]; s_axi_awaddr = bp_src[c]; s_axi_awprot = 3'b000;
      m_axi_awready = bp_mr[c];
      settle();
      check("bp_awready", s_axi_awready, bp_srdy[c]);
      check("bp_m_awvalid", m_axi_awvalid, bp_mv[c]);
      if (bp_mv[c]) check("bp_m_awaddr", m_axi_awaddr, bp_madr[c]);
    end

    // ---- reset while the AR slice is FULL
    step();
    m_axi_arready = 1'b0; s_axi_arvalid = 1'b1; s_axi_araddr = 32'h200;
    settle();
    check("mr_ready0", s_axi_arready, 1'b1);
    step();
    s_axi_araddr = 32'h204;
    settle();
    check("mr_ready1", s_axi_arready, 1'b1);
    step();
    s_axi_arvalid = 1'b0;
    settle();
    check("mr_full_ready", s_axi_arready, 1'b0);
    check("mr_full_addr", m_axi_araddr, 32'h200);
    areset = 1'b1;
    step();
    settle();
    check("mr_rst_valid", m_axi_arvalid, 1'b0);
    check("mr_rst_addr", m_axi_araddr, 32'h0);
    areset = 1'b0; m_axi_arready = 1'b1;
    settle();
    check("mr_rel_ready", s_axi_arready, 1'b1);
    repeat (3) begin
      step();
      settle();
      check("mr_no_ghost", m_axi_arvalid, 1'b0);
    end

    // ---- response latency
    resp_r(32'h1234_5678, 2'b01);

    // ---- random stall scoreboard on AR and R
    step();
    s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0;
    ar_sent = 0; r_sent = 0;
    sb_on = 1'b1;
    settle();
    for (int cyc = 0; cyc < 60000 && !(ar_done >= NumBeats && r_done >= NumBeats); cyc++) begin
      ar_hs = s_axi_arvalid && s_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      step();
      if (ar_hs) ar_sent++;
      if (r_hs) r_sent++;
      if (!s_axi_arvalid || ar_hs) begin
        s_axi_arvalid = (ar_sent < NumBeats) && ($urandom_range(3) != 0);
        s_axi_araddr  = $urandom;
        s_axi_arprot  = 3'($urandom);
      end
      if (!m_axi_rvalid || r_hs) begin
        m_axi_rvalid = (r_sent < NumBeats) && ($urandom_range(3) != 0);
        m_axi_rdata  = $urandom;
        m_axi_rresp  = 2'($urandom);
      end
      m_axi_arready = ($urandom_range(3) != 0);
      s_axi_rready  = ($urandom_range(3) != 0);
      settle();
    end
    sb_on = 1'b0;
    check("ar_sb_count", ar_done, NumBeats);
    check("r_sb_count", r_done, NumBeats);
    check("ar_sb_leftover", ar_q.size(), 0);
    check("r_sb_leftover", r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
